// File: rtl/mem_ctrl.sv
// mem_ctrl: round-robin arbiter over NCH request channels that serialises
// 1/2/4-byte accesses onto an 8-bit memory/IO bus. IO writes wait while the
// UART buffer is full; speculative reads on flushable channels abort on clear.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | bus idle, arbitrating among eligible channels
// ST_READ  | issuing read bytes, capturing mem_din one cycle after issue
// ST_WRITE | issuing write bytes, held off by a full IO buffer
module mem_ctrl #(
  parameter int              NCH        = 2,
  parameter logic [NCH-1:0]  FLUSH_MASK = '1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH-1:0]    req_wr,
  input  logic [2*NCH-1:0]  req_size,
  input  logic [32*NCH-1:0] req_addr,
  input  logic [32*NCH-1:0] req_wdata,
  output logic [NCH-1:0]    resp_ready,
  output logic [31:0]       resp_data,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [31:0]       mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  output logic              busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_t;

  state_t         state_q, state_d;
  logic [2:0]     ptr_q;
  logic [2:0]     ch_q;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [1:0]     last_q;
  logic [2:0]     step_q;
  logic [31:0]    rdata_q;
  logic [NCH-1:0] resp_ready_q;
  logic [31:0]    resp_data_q;
  logic [31:0]    bus_a_q;
  logic [7:0]     bus_dout_q;
  logic           bus_wr_q;

  logic [NCH-1:0] eligible;
  logic           grant_vld;
  logic [2:0]     grant_ch;
  logic [2:0]     nxt_ptr;
  logic [31:0]    g_addr;
  logic [31:0]    g_wdata;
  logic [1:0]     g_size;
  logic [1:0]     g_last;
  logic           g_wr;
  logic [NCH-1:0] ch_onehot;
  logic [2:0]     nxt;
  logic [1:0]     cap_idx;
  logic [31:0]    rdata_d;
  logic           flush_hit;
  logic           read_done;
  logic           write_done;
  logic           io_stall;

  // Round-robin pick: first eligible channel at or after the pointer; a channel
  // being answered this cycle and flushable channels during clear sit out.
  always_comb begin
    eligible = req_valid & ~resp_ready_q;
    if (clear) eligible = eligible & ~FLUSH_MASK;
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!grant_vld && eligible[(int'(ptr_q) + i) % NCH]) begin
        grant_vld = 1'b1;
        grant_ch  = 3'((int'(ptr_q) + i) % NCH);
      end
    end
    nxt_ptr = 3'((int'(grant_ch) + 1) % NCH);
    g_addr  = req_addr[{grant_ch, 5'b00000} +: 32];
    g_wdata = req_wdata[{grant_ch, 5'b00000} +: 32];
    g_size  = req_size[{grant_ch, 1'b0} +: 2];
    g_wr    = req_wr[grant_ch];
    case (g_size)
      2'd0:    g_last = 2'd0;
      2'd1:    g_last = 2'd1;
      default: g_last = 2'd3;
    endcase
  end

  // Per-access decode: byte progress, capture slot, abort and IO hold-off.
  always_comb begin
    ch_onehot          = '0;
    ch_onehot[ch_q]    = 1'b1;
    nxt                = step_q + 3'd1;
    cap_idx            = 2'(step_q - 3'd1);
    rdata_d            = rdata_q;
    if (step_q != 3'd0) rdata_d[{cap_idx, 3'b000} +: 8] = mem_din;
    flush_hit  = clear && FLUSH_MASK[ch_q];
    read_done  = (step_q == ({1'b0, last_q} + 3'd1));
    write_done = (step_q[1:0] == last_q);
    io_stall   = (state_q == ST_WRITE) && (addr_q[17:16] == 2'b11) && io_buffer_full;
  end

  // State register; rdy_in low freezes the machine.
  always_ff @(posedge clk_in) begin
    if (rst_in)      state_q <= ST_IDLE;
    else if (rdy_in) state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant_vld) state_d = g_wr ? ST_WRITE : ST_READ;
      ST_READ:  if (flush_hit || read_done) state_d = ST_IDLE;
      ST_WRITE: if (!io_stall && write_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request latch, byte sequencing, read assembly and registered bus/response.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr_q        <= '0;
      ch_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_q       <= '0;
      step_q       <= '0;
      rdata_q      <= '0;
      resp_ready_q <= '0;
      resp_data_q  <= '0;
      bus_a_q      <= '0;
      bus_dout_q   <= '0;
      bus_wr_q     <= 1'b0;
    end else if (rdy_in) begin
      resp_ready_q <= '0;
      resp_data_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (grant_vld) begin
            ptr_q      <= nxt_ptr;
            ch_q       <= grant_ch;
            addr_q     <= g_addr;
            wdata_q    <= g_wdata;
            last_q     <= g_last;
            step_q     <= '0;
            rdata_q    <= '0;
            bus_a_q    <= g_addr;
            bus_wr_q   <= g_wr;
            bus_dout_q <= g_wr ? g_wdata[7:0] : 8'h00;
          end
        end
        ST_READ: begin
          if (flush_hit) begin
            bus_a_q <= '0;
          end else begin
            rdata_q <= rdata_d;
            if (read_done) begin
              resp_ready_q <= ch_onehot;
              resp_data_q  <= rdata_d;
              bus_a_q      <= '0;
            end else begin
              step_q  <= nxt;
              bus_a_q <= (nxt <= {1'b0, last_q}) ? addr_q + 32'(nxt) : 32'h0;
            end
          end
        end
        ST_WRITE: begin
          if (!io_stall) begin
            if (write_done) begin
              resp_ready_q <= ch_onehot;
              bus_a_q      <= '0;
              bus_wr_q     <= 1'b0;
              bus_dout_q   <= 8'h00;
            end else begin
              step_q     <= nxt;
              bus_a_q    <= addr_q + 32'(nxt);
              bus_dout_q <= wdata_q[{nxt[1:0], 3'b000} +: 8];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Bus gating: a frozen cycle never writes, and a held IO byte shows an idle bus.
  always_comb begin
    mem_wr   = bus_wr_q & rdy_in & ~io_stall;
    mem_a    = io_stall ? 32'h0 : bus_a_q;
    mem_dout = io_stall ? 8'h00 : bus_dout_q;
  end

  assign resp_ready = resp_ready_q;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a synchronous byte memory that freezes with rdy_in.
module tb_mem_ctrl;
  localparam int NCH = 2;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              rdy_in;
  logic              clear;
  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_wr;
  logic [2*NCH-1:0]  req_size;
  logic [32*NCH-1:0] req_addr;
  logic [32*NCH-1:0] req_wdata;
  logic [NCH-1:0]    resp_ready;
  logic [31:0]       resp_data;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [31:0]       mem_a;
  logic              mem_wr;
  logic              io_buffer_full;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  mem_ctrl #(.NCH(NCH), .FLUSH_MASK(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_ready(resp_ready), .resp_data(resp_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .busy(busy)
  );

  // read-only contents preset by the stimulus; writes are logged separately
  logic [7:0]  rom [0:65535];
  logic [7:0]  wmem [0:65535];
  int          wr_count = 0;
  logic [31:0] last_wa = '0;
  logic [7:0]  last_wd = '0;

  always @(posedge clk_in) begin
    if (rdy_in) mem_din <= rom[mem_a[15:0]];
    if (mem_wr) begin
      wmem[mem_a[15:0]] <= mem_dout;
      wr_count <= wr_count + 1;
      last_wa  <= mem_a;
      last_wd  <= mem_dout;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_req(input int c, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
    req_valid[c]          = 1'b1;
    req_wr[c]             = wr;
    req_size[2*c +: 2]    = sz;
    req_addr[32*c +: 32]  = a;
    req_wdata[32*c +: 32] = d;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_mem_a"}, mem_a, 32'h0);
    check_val({tag, "_mem_wr"}, {31'b0, mem_wr}, 32'h0);
    check_val({tag, "_mem_dout"}, {24'b0, mem_dout}, 32'h0);
    check_val({tag, "_resp_ready"}, {30'b0, resp_ready}, 32'h0);
    check_val({tag, "_resp_data"}, resp_data, 32'h0);
    check_val({tag, "_busy"}, {31'b0, busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    logic [31:0] ea;
    logic [31:0] ed;
    logic [1:0]  er;

    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    req_valid = '0; req_wr = '0; req_size = '0; req_addr = '0; req_wdata = '0;
    rom[16'h0100] = 8'h11; rom[16'h0101] = 8'h22; rom[16'h0102] = 8'h33; rom[16'h0103] = 8'h44;
    rom[16'h0010] = 8'hA5; rom[16'h0020] = 8'h5A;

    tick(); tick();
    check_idle_outputs("rst");

    // word read ch0 @0x100
    tick(); rst_in = 1'b0; set_req(0, 1'b0, 2'd2, 32'h100, 32'h0); #1;
    check_val("t1_busy_c0", {31'b0, busy}, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      tick(); if (c == 6) req_valid[0] = 1'b0; #1;
      ea = (c >= 1 && c <= 4) ? 32'h100 + 32'(c - 1) : 32'h0;
      check_val("t1_mem_a", mem_a, ea);
      check_val("t1_mem_wr", {31'b0, mem_wr}, 32'h0);
      check_val("t1_resp", {30'b0, resp_ready}, (c == 6) ? 32'h1 : 32'h0);
      check_val("t1_busy", {31'b0, busy}, (c <= 5) ? 32'h1 : 32'h0);
      if (c == 6) check_val("t1_data", resp_data, 32'h44332211);
    end

    // half write ch1 @0x2002
    tick(); set_req(1, 1'b1, 2'd1, 32'h2002, 32'hDEADBEEF); w0 = wr_count; #1;
    for (int c = 1; c <= 5; c++) begin
      tick(); if (c == 3) req_valid[1] = 1'b0; #1;
      check_val("t2_mem_wr", {31'b0, mem_wr}, (c <= 2) ? 32'h1 : 32'h0);
      check_val("t2_mem_a", mem_a, (c <= 2) ? 32'h2001 + 32'(c) : 32'h0);
      ed = (c == 1) ? 32'hEF : (c == 2) ? 32'hBE : 32'h0;
      check_val("t2_mem_dout", {24'b0, mem_dout}, ed);
      check_val("t2_resp", {30'b0, resp_ready}, (c == 3) ? 32'h2 : 32'h0);
    end
    check_val("t2_wr_count", 32'(wr_count - w0), 32'd2);
    check_val("t2_byte0", {24'b0, wmem[16'h2002]}, 32'hEF);
    check_val("t2_byte1", {24'b0, wmem[16'h2003]}, 32'hBE);

    // IO byte write held by a full UART buffer
    tick(); set_req(0, 1'b1, 2'd0, 32'h30000, 32'h41); w0 = wr_count; #1;
    for (int c = 1; c <= 7; c++) begin
      tick(); io_buffer_full = (c <= 3); if (c == 5) req_valid[0] = 1'b0; #1;
      check_val("t3_mem_wr", {31'b0, mem_wr}, (c == 4) ? 32'h1 : 32'h0);
      check_val("t3_mem_a", mem_a, (c == 4) ? 32'h30000 : 32'h0);
      check_val("t3_mem_dout", {24'b0, mem_dout}, (c == 4) ? 32'h41 : 32'h0);
      check_val("t3_resp", {30'b0, resp_ready}, (c == 5) ? 32'h1 : 32'h0);
    end
    io_buffer_full = 1'b0;
    check_val("t3_wr_count", 32'(wr_count - w0), 32'd1);
    check_val("t3_last_wa", last_wa, 32'h30000);
    check_val("t3_last_wd", {24'b0, last_wd}, 32'h41);

    // round robin from reset, both channels issuing byte reads continuously
    tick(); rst_in = 1'b1;
    tick(); #1;
    check_idle_outputs("rst2");
    tick(); rst_in = 1'b0;
    set_req(0, 1'b0, 2'd0, 32'h10, 32'h0);
    set_req(1, 1'b0, 2'd0, 32'h20, 32'h0);
    #1;
    for (int c = 1; c <= 13; c++) begin
      tick(); if (c == 13) req_valid = '0; #1;
      er = (c % 3 != 0) ? 2'b00 : (((c / 3) % 2) == 1) ? 2'b01 : 2'b10;
      check_val("t4_resp", {30'b0, resp_ready}, {30'b0, er});
      if (er == 2'b01) check_val("t4_data0", resp_data, 32'hA5);
      if (er == 2'b10) check_val("t4_data1", resp_data, 32'h5A);
      ea = (c % 3 != 1) ? 32'h0 : (((c / 3) % 2) == 0) ? 32'h10 : 32'h20;
      check_val("t4_mem_a", mem_a, ea);
    end
    for (int i = 0; i < 20 && busy; i++) tick();
    check_val("t4_drain", {31'b0, busy}, 32'h0);
    tick();

    // single channel back to back: same channel waits one cycle after its response
    tick(); set_req(0, 1'b0, 2'd0, 32'h10, 32'h0); #1;
    for (int c = 1; c <= 7; c++) begin
      tick(); if (c == 7) req_valid[0] = 1'b0; #1;
      check_val("t5_resp", {30'b0, resp_ready}, (c == 3 || c == 7) ? 32'h1 : 32'h0);
      check_val("t5_mem_a", mem_a, (c == 1 || c == 5) ? 32'h10 : 32'h0);
    end
    tick(); tick();

    // clear in cycle 2 of a word read on ch0 aborts it
    tick(); set_req(0, 1'b0, 2'd2, 32'h100, 32'h0); #1;
    for (int c = 1; c <= 6; c++) begin
      tick(); clear = (c == 2); if (c == 2) req_valid[0] = 1'b0; #1;
      check_val("t6_busy", {31'b0, busy}, (c <= 2) ? 32'h1 : 32'h0);
      check_val("t6_resp", {30'b0, resp_ready}, 32'h0);
      ea = (c == 1) ? 32'h100 : (c == 2) ? 32'h101 : 32'h0;
      check_val("t6_mem_a", mem_a, ea);
    end
    clear = 1'b0;

    // clear in cycle 2 of a word write on ch1 has no effect
    tick(); set_req(1, 1'b1, 2'd2, 32'h3000, 32'h01020304); w0 = wr_count; #1;
    for (int c = 1; c <= 7; c++) begin
      tick(); clear = (c == 2); if (c == 5) req_valid[1] = 1'b0; #1;
      check_val("t7_mem_wr", {31'b0, mem_wr}, (c <= 4) ? 32'h1 : 32'h0);
      check_val("t7_mem_a", mem_a, (c <= 4) ? 32'h2FFF + 32'(c) : 32'h0);
      check_val("t7_resp", {30'b0, resp_ready}, (c == 5) ? 32'h2 : 32'h0);
    end
    clear = 1'b0;
    check_val("t7_wr_count", 32'(wr_count - w0), 32'd4);
    check_val("t7_mem", {wmem[16'h3003], wmem[16'h3002], wmem[16'h3001], wmem[16'h3000]}, 32'h01020304);

    // rdy_in low in cycles 2-4 of a word read delays it by three cycles
    tick(); set_req(0, 1'b0, 2'd2, 32'h100, 32'h0); #1;
    for (int c = 1; c <= 10; c++) begin
      tick(); rdy_in = !(c >= 2 && c <= 4); if (c == 9) req_valid[0] = 1'b0; #1;
      ea = (c == 1) ? 32'h100 : (c <= 5) ? 32'h101 : (c == 6) ? 32'h102 : (c == 7) ? 32'h103 : 32'h0;
      check_val("t8_mem_a", mem_a, ea);
      check_val("t8_mem_wr", {31'b0, mem_wr}, 32'h0);
      check_val("t8_resp", {30'b0, resp_ready}, (c == 9) ? 32'h1 : 32'h0);
      check_val("t8_busy", {31'b0, busy}, (c <= 8) ? 32'h1 : 32'h0);
      if (c == 9) check_val("t8_data", resp_data, 32'h44332211);
    end

    // word write with rdy_in low in cycle 2 and reset in cycle 3
    tick(); set_req(0, 1'b1, 2'd2, 32'h400, 32'hCAFEF00D); w0 = wr_count; #1;
    for (int c = 1; c <= 6; c++) begin
      tick(); rdy_in = (c != 2); rst_in = (c == 3); if (c == 3) req_valid[0] = 1'b0; #1;
      check_val("t9_mem_wr", {31'b0, mem_wr}, (c == 1 || c == 3) ? 32'h1 : 32'h0);
      ea = (c == 1) ? 32'h400 : (c <= 3) ? 32'h401 : 32'h0;
      check_val("t9_mem_a", mem_a, ea);
      ed = (c == 1) ? 32'h0D : (c <= 3) ? 32'hF0 : 32'h0;
      check_val("t9_mem_dout", {24'b0, mem_dout}, ed);
      check_val("t9_resp", {30'b0, resp_ready}, 32'h0);
      check_val("t9_busy", {31'b0, busy}, (c <= 3) ? 32'h1 : 32'h0);
      if (c >= 4) check_idle_outputs("t9_after_rst");
    end
    rst_in = 1'b0;
    check_val("t9_wr_count", 32'(wr_count - w0), 32'd2);
    check_val("t9_byte0", {24'b0, wmem[16'h0400]}, 32'h0D);
    check_val("t9_byte1", {24'b0, wmem[16'h0401]}, 32'hF0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
